// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM state encodings, requester count and the default hold limit.
package rr_arbiter4_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int NREQ         = 4;
   localparam int MAX_HOLD_DEF = 4;

endpackage

// File: rtl/decoder2x4.sv
// 2-to-4 one-hot decoder: d[i] is high when {a,b} == i, with a as the MSB.
module decoder2x4 (
   input  logic       a,
   input  logic       b,
   output logic [3:0] d
);

   assign d[0] = ~a & ~b;
   assign d[1] = ~a &  b;
   assign d[2] =  a & ~b;
   assign d[3] =  a &  b;

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority search: the first requester with req high in the order
// last+1, last+2, last+3, last+4 (mod 4) wins. Purely combinational.
module rr_pick4
   import rr_arbiter4_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      last,
   output logic [1:0]      win_idx,
   output logic            any_req
);

   // Walk the search order from farthest to nearest so the nearest hit is the last write.
   always_comb begin
      logic [1:0] cand;
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      win_idx = last;
      cand    = last;
      for (int k = NREQ; k >= 1; k--) begin
         cand = last + 2'(k);
         if (req[cand]) win_idx = cand;
      end
      any_req = |req;
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// The owner keeps the grant while requesting; after MAX_HOLD cycles it is
// forced to yield if anyone else is waiting. Grant outputs are registered.
// Optional macro RR_ARB_LOCK_EN adds a 'lock' input that suppresses the
// forced rotation while the owner is still requesting.
module rr_arbiter4
   import rr_arbiter4_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int CW       = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      req,
`ifdef RR_ARB_LOCK_EN
   input  logic            lock,
`endif
   output logic [3:0]      gnt,
   output logic [1:0]      gnt_idx,
   output logic            gnt_vld,
   output logic [CW-1:0]   busy_cnt
);

   state_t          state_q, state_d;
   logic [1:0]      last_q,  last_d;
   logic [1:0]      idx_q,   idx_d;
   logic            vld_q,   vld_d;
   logic [CW-1:0]   busy_q,  busy_d;
   logic [3:0]      gnt_q,   gnt_d;

   logic [1:0]      win_idx;
   logic            any_req;
   logic [3:0]      dec_out;
   logic            other_req;
   logic            at_limit;
   logic            hold_lock;

`ifdef RR_ARB_LOCK_EN
   assign hold_lock = lock;
`else
   assign hold_lock = 1'b0;
`endif

   rr_pick4 u_pick (
      .req     (req),
      .last    (last_q),
      .win_idx (win_idx),
      .any_req (any_req)
   );

   decoder2x4 u_dec (
      .a (idx_d[1]),
      .b (idx_d[0]),
      .d (dec_out)
   );

   // gnt_q is one-hot of the owner while granting, so masking it isolates the waiters.
   assign other_req = |(req & ~gnt_q);
   assign at_limit  = (busy_q == CW'(MAX_HOLD));
   assign gnt_d     = dec_out & {4{vld_d}};

   // Next-state decision: idle acquire, release/hand-off, forced rotation, or hold.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_GRANT;
               idx_d   = win_idx;
               last_d  = win_idx;
               vld_d   = 1'b1;
               busy_d  = CW'(1);
            end else begin
               vld_d   = 1'b0;
               busy_d  = '0;
            end
         end
         ST_GRANT: begin
            if (!req[idx_q]) begin
               // Owner released: hand off directly, or fall back to idle.
               if (other_req) begin
                  idx_d   = win_idx;
                  last_d  = win_idx;
                  busy_d  = CW'(1);
               end else begin
                  state_d = ST_IDLE;
                  vld_d   = 1'b0;
                  busy_d  = '0;
               end
            end else if (at_limit && other_req && !hold_lock) begin
               // Hold limit reached with someone waiting: rotate past the owner.
               idx_d  = win_idx;
               last_d = win_idx;
               busy_d = CW'(1);
            end else begin
               busy_d = at_limit ? busy_q : busy_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            busy_d  = '0;
         end
      endcase
   end

   // State and registered outputs; last=3 makes requester 0 first after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= 2'd3;
         idx_q   <= 2'd0;
         vld_q   <= 1'b0;
         busy_q  <= '0;
         gnt_q   <= 4'b0000;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q <= state_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         gnt_q   <= gnt_d;
      end
   end

   assign gnt      = gnt_q;
   assign gnt_idx  = idx_q;
   assign gnt_vld  = vld_q;
   assign busy_cnt = busy_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed testbench for rr_arbiter4 (MAX_HOLD=4, CW=4). Define
// RR_ARB_LOCK_EN for both RTL and bench to exercise the lock input.
module tb_rr_arbiter4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic [3:0] busy_cnt;
`ifdef RR_ARB_LOCK_EN
   logic       lock;
`endif

   int total;
   int bad;

   rr_arbiter4 #(
      .MAX_HOLD (4),
      .CW       (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
`ifdef RR_ARB_LOCK_EN
      .lock     (lock),
`endif
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .gnt_vld  (gnt_vld),
      .busy_cnt (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = 4'b0000;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({gnt, gnt_idx, gnt_vld, busy_cnt} !== 11'd0) begin
         bad++;
         $display("FAIL reset_outputs: got gnt=%b idx=%0d vld=%b busy=%0d want all zero",
                  gnt, gnt_idx, gnt_vld, busy_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0001;
      tick();
      total++;
      if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_vld !== 1'b1 || busy_cnt !== 4'd1) begin
         bad++;
         $display("FAIL single_grant: got gnt=%b idx=%0d vld=%b busy=%0d want 0001/0/1/1",
                  gnt, gnt_idx, gnt_vld, busy_cnt);
      end
      req = 4'b0000;
      tick();
      total++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
         bad++;
         $display("FAIL release_idle: got gnt=%b vld=%b want 0000/0", gnt, gnt_vld);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_gnt;
      logic [3:0] exp_busy;
      int         owner;
      do_reset();
      req = 4'b1111;
      for (int t = 0; t < 20; t++) begin
         tick();
         owner    = (t / 4) % 4;
         exp_gnt  = 4'b0001 << owner;
         exp_busy = 4'((t % 4) + 1);
         total++;
         if (gnt !== exp_gnt || gnt_idx !== 2'(owner) || busy_cnt !== exp_busy) begin
            bad++;
            $display("FAIL rotate_t%0d: got gnt=%b idx=%0d busy=%0d want %b/%0d/%0d",
                     t, gnt, gnt_idx, busy_cnt, exp_gnt, owner, exp_busy);
         end
         total++;
         if (((gnt & (gnt - 4'd1)) !== 4'd0) || (gnt[gnt_idx] !== gnt_vld)) begin
            bad++;
            $display("FAIL onehot_t%0d: got gnt=%b idx=%0d vld=%b want one-hot consistent",
                     t, gnt, gnt_idx, gnt_vld);
         end
      end
   endtask

   task automatic test_release_handoff();
      do_reset();
      req = 4'b0100;
      tick();
      req = 4'b0101;
      tick();
      total++;
      if (gnt !== 4'b0100 || busy_cnt !== 4'd2) begin
         bad++;
         $display("FAIL owner2_hold: got gnt=%b busy=%0d want 0100/2", gnt, busy_cnt);
      end
      req = 4'b0001;
      tick();
      total++;
      if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_vld !== 1'b1 || busy_cnt !== 4'd1) begin
         bad++;
         $display("FAIL handoff: got gnt=%b idx=%0d vld=%b busy=%0d want 0001/0/1/1",
                  gnt, gnt_idx, gnt_vld, busy_cnt);
      end
   endtask

   task automatic test_lone_saturate();
      logic [3:0] exp_busy;
      do_reset();
      req = 4'b0100;
      for (int t = 0; t < 20; t++) begin
         tick();
         exp_busy = (t < 4) ? 4'(t + 1) : 4'd4;
         total++;
         if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || busy_cnt !== exp_busy) begin
            bad++;
            $display("FAIL lone_t%0d: got gnt=%b idx=%0d busy=%0d want 0100/2/%0d",
                     t, gnt, gnt_idx, busy_cnt, exp_busy);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0010;
      tick();
      total++;
      if (gnt !== 4'b0010) begin
         bad++;
         $display("FAIL pre_reset_grant: got gnt=%b want 0010", gnt);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || busy_cnt !== 4'd0) begin
         bad++;
         $display("FAIL async_reset: got gnt=%b vld=%b busy=%0d want 0000/0/0",
                  gnt, gnt_vld, busy_cnt);
      end
      req = 4'b1001;
      @(negedge clk);
      rst = 1'b0;
      tick();
      total++;
      if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
         bad++;
         $display("FAIL post_reset_prio: got gnt=%b idx=%0d want 0001/0", gnt, gnt_idx);
      end
      for (int t = 0; t < 3; t++) tick();
      total++;
      if (gnt !== 4'b0001 || busy_cnt !== 4'd4) begin
         bad++;
         $display("FAIL hold_limit: got gnt=%b busy=%0d want 0001/4", gnt, busy_cnt);
      end
      tick();
      total++;
      if (gnt !== 4'b1000 || gnt_idx !== 2'd3 || busy_cnt !== 4'd1) begin
         bad++;
         $display("FAIL forced_rotate: got gnt=%b idx=%0d busy=%0d want 1000/3/1",
                  gnt, gnt_idx, busy_cnt);
      end
   endtask

`ifdef RR_ARB_LOCK_EN
   task automatic test_lock();
      logic [3:0] exp_busy;
      lock = 1'b0;
      do_reset();
      req = 4'b0011;
      tick();
      lock = 1'b1;
      for (int t = 0; t < 10; t++) begin
         tick();
         exp_busy = (t < 3) ? 4'(t + 2) : 4'd4;
         total++;
         if (gnt !== 4'b0001 || busy_cnt !== exp_busy) begin
            bad++;
            $display("FAIL lock_t%0d: got gnt=%b busy=%0d want 0001/%0d",
                     t, gnt, busy_cnt, exp_busy);
         end
      end
      lock = 1'b0;
      tick();
      total++;
      if (gnt !== 4'b0010 || busy_cnt !== 4'd1) begin
         bad++;
         $display("FAIL unlock_rotate: got gnt=%b busy=%0d want 0010/1", gnt, busy_cnt);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      req   = 4'b0000;
`ifdef RR_ARB_LOCK_EN
      lock  = 1'b0;
`endif
      test_reset();
      test_rotation();
      test_release_handoff();
      test_lone_saturate();
      test_async_reset();
`ifdef RR_ARB_LOCK_EN
      test_lock();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource, such as a bus or an adder slot, between requesters 0..3.
- Picks a 2-bit winner index and expands it to a one-hot grant through the team's existing decoder2x4. D[i] is asserted when {a,b}==i, with a as MSB.
- Holds a grant while the owner keeps requesting, bounded by a hold limit, then rotates to the next requester.
- Sits between requester FSMs and the shared datapath enable.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester may own the grant while another requester is waiting. Legal range 1..15.
- CW, 4: width of the hold counter. Must satisfy 2^CW > MAX_HOLD.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- req, input, 4: request vector; req[i] high means requester i wants the resource.
- gnt, output, 4: registered one-hot grant, or all zeros when idle.
- gnt_idx, output, 2: index of the current owner; valid when gnt_vld=1.
- gnt_vld, output, 1: high when any grant is active.
- busy_cnt, output, CW: registered cycles-owned count of the current owner.

Behaviour:
- Reset (async, rst=1): gnt=4'b0000, gnt_idx=2'd0, gnt_vld=0, busy_cnt=0, state=IDLE, last=2'd3. last=3 makes requester 0 highest priority after reset.
- Search order: (last+1), (last+2), (last+3), (last+4) mod 4. The first requester with req high in that order wins. Index wrap-around is natural 2-bit overflow.
- Latency: a grant appears 1 clk after req is sampled high. gnt, gnt_idx and gnt_vld are all registered.
- FSM states and transitions:
  - IDLE: gnt=0. If any req is high, go to GRANT with the search winner; busy_cnt=1; last=winner. Otherwise stay in IDLE.
  - GRANT: on each edge, evaluate in this order:
    - (a) req[gnt_idx]==0 (owner released): if any other req is high, switch directly to the search winner with no idle bubble and busy_cnt=1. Otherwise go to IDLE.
    - (b) Owner still requesting, busy_cnt==MAX_HOLD, and some other req is high: forced rotation to the search winner, starting after the current owner; busy_cnt=1.
    - (c) Otherwise keep the grant. busy_cnt increments, saturating at MAX_HOLD.
- A lone requester keeps the grant indefinitely. busy_cnt sits at MAX_HOLD and no re-grant pulse is generated.
- Simultaneous requests: resolved strictly by rotating priority; no starvation. Worst-case wait is 3*MAX_HOLD+1 cycles.
- A req that drops and rises in the same cycle as the switch is treated per the value sampled at the clock edge.
- Reset mid-grant: gnt drops immediately (asynchronous) and priority restarts from requester 0.
- Invariant: gnt is always zero or one-hot, and gnt[gnt_idx]==gnt_vld.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While lock=1 and the owner's req=1, rule (b) is suppressed, so the owner keeps the grant past MAX_HOLD.
  - busy_cnt still saturates.
  - lock has no effect in IDLE.
- Undefined: no lock port; behaviour is exactly as above.

Decomposition:
- Shared header rr_arb_defs.vh holds:
  - state encodings: ST_IDLE=1'b0, ST_GRANT=1'b1.
  - NREQ=4.
  - the default MAX_HOLD.
- One sub-module, rr_pick4 (combinational): inputs req[3:0] and last[1:0]; outputs win_idx[1:0] and any_req.
- The top instantiates rr_pick4 plus decoder2x4 (a=idx[1], b=idx[0]). The decoder output is gated by gnt_vld and then registered.

Test Plan:
1. Reset, then req=4'b0001 -> after 1 clk gnt=0001, gnt_idx=0, gnt_vld=1. Drop req -> next clk gnt=0000, gnt_vld=0.
2. req=4'b1111 held, MAX_HOLD=4 -> grants rotate 0,1,2,3,0 with each owner holding exactly 4 cycles; gnt is one-hot every cycle.
3. Owner 2 holds and req[2] falls while req[0]=1 -> next clk gnt=0001 with no idle cycle and busy_cnt=1.
4. req=4'b0100 alone for 20 cycles -> gnt=0100 throughout and busy_cnt saturates at 4.
5. rst asserted mid-grant between clock edges -> gnt=0 immediately. After release with req=4'b1001 -> requester 0 is granted first.
6. (RR_ARB_LOCK_EN) req=4'b0011, owner 0, lock=1 for 10 cycles -> gnt stays 0001. After lock=0 -> gnt=0010 on the next edge.
